// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Purpose  : Handshaked execute ALU, registered output, iterative MUL/MULHU.
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1,
   parameter int TAG_W          = 5,
   parameter int ENABLE_MUL     = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [3:0]       alu_op_i,
   input  logic [XLEN-1:0]  alu_a_i,
   input  logic [XLEN-1:0]  alu_b_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [XLEN-1:0]  alu_result_o,
   output logic [TAG_W-1:0] tag_o,
   output logic             illegal_o,
   output logic             busy_o
);
   localparam int c_SHW   = $clog2(XLEN);
   localparam int c_STEPS = XLEN / BITS_PER_CYCLE;
   localparam int c_CNT_W = $clog2(c_STEPS + 1);

   localparam logic [3:0] c_OP_ADD   = 4'd0;
   localparam logic [3:0] c_OP_AND   = 4'd1;
   localparam logic [3:0] c_OP_SLL   = 4'd2;
   localparam logic [3:0] c_OP_SRL   = 4'd3;
   localparam logic [3:0] c_OP_OR    = 4'd4;
   localparam logic [3:0] c_OP_XOR   = 4'd5;
   localparam logic [3:0] c_OP_SLT   = 4'd6;
   localparam logic [3:0] c_OP_SLTU  = 4'd7;
   localparam logic [3:0] c_OP_SRA   = 4'd8;
   localparam logic [3:0] c_OP_LUI   = 4'd9;
   localparam logic [3:0] c_OP_SUB   = 4'd10;
   localparam logic [3:0] c_OP_MUL   = 4'd11;
   localparam logic [3:0] c_OP_MULHU = 4'd12;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

   state_t              r_state;
   logic [c_CNT_W-1:0]  r_cnt;
   logic [2*XLEN-1:0]   r_acc;
   logic [2*XLEN-1:0]   r_mcand;
   logic [XLEN-1:0]     r_mplier;
   logic                r_mul_hi;
   logic [TAG_W-1:0]    r_mtag;
   logic                r_out_valid;
   logic [XLEN-1:0]     r_result;
   logic [TAG_W-1:0]    r_tag;
   logic                r_illegal;

   logic [c_SHW-1:0]    w_shamt;
   logic [XLEN-1:0]     w_alu;
   logic                w_is_mulop;
   logic                w_is_mul;
   logic                w_illegal;
   logic                w_out_free;
   logic                w_in_ready;
   logic                w_accept;
   logic [2*XLEN-1:0]   w_partial;

   assign w_shamt    = alu_b_i[c_SHW-1:0];
   assign w_is_mulop = (alu_op_i == c_OP_MUL) || (alu_op_i == c_OP_MULHU);
   assign w_is_mul   = (ENABLE_MUL != 0) && w_is_mulop;
   assign w_illegal  = (alu_op_i > c_OP_MULHU) || ((ENABLE_MUL == 0) && w_is_mulop);
   assign w_out_free = !r_out_valid || out_ready_i;
   assign w_in_ready = !rst && (r_state == S_IDLE) && w_out_free;
   assign w_accept   = in_valid_i && w_in_ready;

   always_comb begin
      w_alu = '0;
      case (alu_op_i)
         c_OP_ADD:  w_alu = alu_a_i + alu_b_i;
         c_OP_AND:  w_alu = alu_a_i & alu_b_i;
         c_OP_SLL:  w_alu = alu_a_i << w_shamt;
         c_OP_SRL:  w_alu = alu_a_i >> w_shamt;
         c_OP_OR:   w_alu = alu_a_i | alu_b_i;
         c_OP_XOR:  w_alu = alu_a_i ^ alu_b_i;
         c_OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(alu_a_i) < $signed(alu_b_i)};
         c_OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, alu_a_i < alu_b_i};
         c_OP_SRA:  w_alu = $signed(alu_a_i) >>> w_shamt;
         c_OP_LUI:  w_alu = alu_b_i << 12;
         c_OP_SUB:  w_alu = alu_a_i - alu_b_i;
         default:   w_alu = '0;
      endcase
   end

   // One slice of the shift-add product: the low multiplier bits select shifted multiplicands.
   generate
      if (ENABLE_MUL != 0) begin : g_mul
         always_comb begin
            w_partial = '0;
            for (int i = 0; i < BITS_PER_CYCLE; i++) begin
               if (r_mplier[i]) w_partial = w_partial + (r_mcand << i);
            end
         end
      end else begin : g_no_mul
         assign w_partial = '0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_mul_hi    <= 1'b0;
         r_mtag      <= '0;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_tag       <= '0;
         r_illegal   <= 1'b0;
      end else begin
         if (out_ready_i) r_out_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept && w_is_mul) begin
                  r_state  <= S_BUSY;
                  r_cnt    <= c_CNT_W'(c_STEPS);
                  r_acc    <= '0;
                  r_mcand  <= {{XLEN{1'b0}}, alu_a_i};
                  r_mplier <= alu_b_i;
                  r_mul_hi <= (alu_op_i == c_OP_MULHU);
                  r_mtag   <= tag_i;
               end else if (w_accept) begin
                  r_out_valid <= 1'b1;
                  r_result    <= w_alu;
                  r_tag       <= tag_i;
                  r_illegal   <= w_illegal;
               end
            end
            S_BUSY: begin
               r_acc    <= r_acc + w_partial;
               r_mcand  <= r_mcand << BITS_PER_CYCLE;
               r_mplier <= r_mplier >> BITS_PER_CYCLE;
               r_cnt    <= r_cnt - c_CNT_W'(1);
               if (r_cnt == c_CNT_W'(1)) r_state <= S_DONE;
            end
            S_DONE: begin
               // Wait here until a stalled previous result has been taken.
               if (w_out_free) begin
                  r_out_valid <= 1'b1;
                  r_result    <= r_mul_hi ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
                  r_tag       <= r_mtag;
                  r_illegal   <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready_o   = w_in_ready;
   assign out_valid_o  = r_out_valid;
   assign alu_result_o = r_result;
   assign tag_o        = r_tag;
   assign illegal_o    = r_illegal;
   assign busy_o       = (r_state == S_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Purpose  : Self-checking bench for alu_pipe (default and multiplier-less).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;
   localparam int XLEN  = 32;
   localparam int TAG_W = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic             in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, illegal, busy;
   logic [3:0]       op = '0;
   logic [XLEN-1:0]  a = '0, b = '0, result;
   logic [TAG_W-1:0] tag = '0, tag_out;

   logic             n_in_valid = 1'b0, n_in_ready, n_out_valid, n_out_ready = 1'b1, n_illegal, n_busy;
   logic [3:0]       n_op = '0;
   logic [XLEN-1:0]  n_a = '0, n_b = '0, n_result;
   logic [TAG_W-1:0] n_tag = '0, n_tag_out;

   int compared   = 0;
   int mismatched = 0;

   alu_pipe #(.XLEN(XLEN), .BITS_PER_CYCLE(1), .TAG_W(TAG_W), .ENABLE_MUL(1)) dut (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .alu_op_i(op), .alu_a_i(a), .alu_b_i(b), .tag_i(tag),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .alu_result_o(result),
      .tag_o(tag_out), .illegal_o(illegal), .busy_o(busy));

   alu_pipe #(.XLEN(XLEN), .BITS_PER_CYCLE(1), .TAG_W(TAG_W), .ENABLE_MUL(0)) dut_nm (
      .clk(clk), .rst(rst), .in_valid_i(n_in_valid), .in_ready_o(n_in_ready),
      .alu_op_i(n_op), .alu_a_i(n_a), .alu_b_i(n_b), .tag_i(n_tag),
      .out_valid_o(n_out_valid), .out_ready_i(n_out_ready), .alu_result_o(n_result),
      .tag_o(n_tag_out), .illegal_o(n_illegal), .busy_o(n_busy));

   // Reference: {illegal, result} from the opcode table with plain arithmetic.
   function automatic logic [XLEN:0] ref_alu(input logic [3:0] f_op, input logic [XLEN-1:0] fa,
                                            input logic [XLEN-1:0] fb, input bit has_mul);
      logic [2*XLEN-1:0] prod;
      logic [XLEN-1:0]   r;
      logic              ill;
      int                s;
      s    = int'(fb % XLEN);
      prod = {{XLEN{1'b0}}, fa} * {{XLEN{1'b0}}, fb};
      ill  = 1'b0;
      r    = '0;
      case (f_op)
         4'd0:  r = fa + fb;
         4'd1:  r = fa & fb;
         4'd2:  r = fa << s;
         4'd3:  r = fa >> s;
         4'd4:  r = fa | fb;
         4'd5:  r = fa ^ fb;
         4'd6:  r = ((fa ^ 32'h8000_0000) < (fb ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
         4'd7:  r = (fa < fb) ? 32'd1 : 32'd0;
         4'd8:  r = (fa >> s) | (fa[XLEN-1] ? ~({XLEN{1'b1}} >> s) : '0);
         4'd9:  r = fb << 12;
         4'd10: r = fa - fb;
         4'd11: if (has_mul) r = prod[XLEN-1:0];    else ill = 1'b1;
         4'd12: if (has_mul) r = prod[2*XLEN-1:XLEN]; else ill = 1'b1;
         default: ill = 1'b1;
      endcase
      return {ill, r};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] d_op, input logic [XLEN-1:0] da,
                        input logic [XLEN-1:0] db, input logic [TAG_W-1:0] dt);
      in_valid = 1'b1; op = d_op; a = da; b = db; tag = dt;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; n_in_valid = 1'b0; out_ready = 1'b1; n_out_ready = 1'b1;
      tick(); tick();
      compared++;
      if ({out_valid, result, tag_out, illegal, busy} !== '0) begin
         mismatched++;
         $display("FAIL reset_outputs: got v=%b r=%h t=%h i=%b b=%b want all zero",
                  out_valid, result, tag_out, illegal, busy);
      end
      compared++;
      if (in_ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready: got %b want 0", in_ready); end
      rst = 1'b0;
      #1;
      compared++;
      if ({in_ready, n_in_ready} !== 2'b11) begin
         mismatched++; $display("FAIL ready_after_reset: got %b want 11", {in_ready, n_in_ready});
      end
   endtask

   task automatic test_add();
      drive(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd3);
      tick();
      in_valid = 1'b0;
      compared++;
      if ({out_valid, result, tag_out, illegal} !== {1'b1, 32'h0, 5'd3, 1'b0}) begin
         mismatched++;
         $display("FAIL add_wrap: got v=%b r=%h t=%0d i=%b want v=1 r=00000000 t=3 i=0",
                  out_valid, result, tag_out, illegal);
      end
      tick();
      compared++;
      if (out_valid !== 1'b0) begin mismatched++; $display("FAIL add_drain: got valid %b want 0", out_valid); end
   endtask

   task automatic test_stream();
      logic [3:0]       ops [4];
      logic [XLEN-1:0]  as  [4];
      logic [XLEN-1:0]  bs  [4];
      logic [XLEN-1:0]  ex  [4];
      logic [XLEN:0]    exp_v;
      int               r;
      ops = '{4'd10, 4'd8, 4'd6, 4'd7};
      as  = '{$urandom(), 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      bs  = '{$urandom(), 32'h0000_0024, 32'h1, 32'h1};
      ex  = '{as[0] - bs[0], 32'hF800_0000, 32'h1, 32'h0};
      for (int i = 0; i < 4; i++) begin
         drive(ops[i], as[i], bs[i], 5'(i));
         tick();
         compared++;
         if ({out_valid, result, tag_out} !== {1'b1, ex[i], 5'(i)}) begin
            mismatched++;
            $display("FAIL stream_%0d: got v=%b r=%h t=%0d want v=1 r=%h t=%0d",
                     i, out_valid, result, tag_out, ex[i], i);
         end
      end
      // Random single-cycle ops at full rate.
      for (int i = 0; i < 30; i++) begin
         r = $urandom_range(0, 13);
         drive(4'(r >= 11 ? r + 2 : r), $urandom(), $urandom(), 5'($urandom()));
         exp_v = ref_alu(op, a, b, 1'b1);
         tick();
         compared++;
         if ({out_valid, illegal, result, tag_out} !== {1'b1, exp_v, tag}) begin
            mismatched++;
            $display("FAIL rand_stream op=%0d: got v=%b i=%b r=%h t=%0d want v=1 i=%b r=%h t=%0d",
                     op, out_valid, illegal, result, tag_out, exp_v[XLEN], exp_v[XLEN-1:0], tag);
         end
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_mul(input logic [3:0] m_op, input logic [XLEN-1:0] ma,
                           input logic [XLEN-1:0] mb, input logic [XLEN-1:0] want);
      int k, lows, busys;
      drive(m_op, ma, mb, 5'd12);
      tick();
      in_valid = 1'b0;
      k = 0; lows = 0; busys = 0;
      while (out_valid !== 1'b1 && k < 100) begin
         if (in_ready === 1'b0) lows++;
         if (busy === 1'b1) busys++;
         tick();
         k++;
      end
      compared++;
      if (k != 33) begin mismatched++; $display("FAIL mul_latency op=%0d: got %0d want 33", m_op, k); end
      compared++;
      if (lows != 33 || busys != 32) begin
         mismatched++;
         $display("FAIL mul_ready_busy op=%0d: got ready_low=%0d busy=%0d want 33/32", m_op, lows, busys);
      end
      compared++;
      if ({result, tag_out, illegal} !== {want, 5'd12, 1'b0}) begin
         mismatched++;
         $display("FAIL mul_result op=%0d: got r=%h t=%0d i=%b want r=%h t=12 i=0",
                  m_op, result, tag_out, illegal, want);
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic [XLEN-1:0] xa, xb, oa, ob;
      int bad;
      xa = $urandom(); xb = $urandom(); oa = $urandom(); ob = $urandom();
      out_ready = 1'b0;
      drive(4'd5, xa, xb, 5'd21);
      tick();
      drive(4'd4, oa, ob, 5'd22);
      compared++;
      if ({out_valid, result, tag_out} !== {1'b1, xa ^ xb, 5'd21}) begin
         mismatched++;
         $display("FAIL bp_xor: got v=%b r=%h t=%0d want v=1 r=%h t=21", out_valid, result, tag_out, xa ^ xb);
      end
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (in_ready !== 1'b0 || {out_valid, result, tag_out} !== {1'b1, xa ^ xb, 5'd21}) bad++;
         tick();
      end
      compared++;
      if (bad != 0) begin mismatched++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
      out_ready = 1'b1;
      #1;
      compared++;
      if (in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
      tick();
      in_valid = 1'b0;
      compared++;
      if ({out_valid, result, tag_out} !== {1'b1, oa | ob, 5'd22}) begin
         mismatched++;
         $display("FAIL bp_no_bubble: got v=%b r=%h t=%0d want v=1 r=%h t=22", out_valid, result, tag_out, oa | ob);
      end
      tick();
   endtask

   task automatic test_illegal();
      drive(4'd14, $urandom(), $urandom(), 5'd7);
      tick();
      in_valid = 1'b0;
      compared++;
      if ({out_valid, result, tag_out, illegal} !== {1'b1, 32'h0, 5'd7, 1'b1}) begin
         mismatched++;
         $display("FAIL illegal_14: got v=%b r=%h t=%0d i=%b want v=1 r=0 t=7 i=1",
                  out_valid, result, tag_out, illegal);
      end
      for (int i = 11; i <= 12; i++) begin
         n_in_valid = 1'b1; n_op = 4'(i); n_a = $urandom(); n_b = $urandom(); n_tag = 5'd7;
         tick();
         compared++;
         if ({n_out_valid, n_result, n_tag_out, n_illegal, n_busy} !== {1'b1, 32'h0, 5'd7, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL nomul_op%0d: got v=%b r=%h t=%0d i=%b b=%b want v=1 r=0 t=7 i=1 b=0",
                     i, n_out_valid, n_result, n_tag_out, n_illegal, n_busy);
         end
      end
      n_op = 4'd0; n_a = 32'd5; n_b = 32'd6; n_tag = 5'd1;
      tick();
      n_in_valid = 1'b0;
      compared++;
      if ({n_out_valid, n_result, n_illegal} !== {1'b1, 32'd11, 1'b0}) begin
         mismatched++;
         $display("FAIL nomul_add: got v=%b r=%h i=%b want v=1 r=0000000b i=0", n_out_valid, n_result, n_illegal);
      end
      tick();
   endtask

   task automatic test_reset_mid_mul();
      int seen;
      drive(4'd11, 32'h0001_0003, 32'h0002_0005, 5'd4);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      rst = 1'b1;
      tick();
      compared++;
      if ({out_valid, busy} !== 2'b00) begin
         mismatched++; $display("FAIL midrst_state: got v=%b b=%b want 0/0", out_valid, busy);
      end
      rst = 1'b0;
      #1;
      compared++;
      if (in_ready !== 1'b1) begin mismatched++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
         tick();
      end
      compared++;
      if (seen != 0) begin mismatched++; $display("FAIL midrst_discard: got %0d active cycles want 0", seen); end
      drive(4'd0, 32'd2, 32'd2, 5'd9);
      tick();
      in_valid = 1'b0;
      compared++;
      if ({out_valid, result, tag_out} !== {1'b1, 32'd4, 5'd9}) begin
         mismatched++;
         $display("FAIL midrst_add: got v=%b r=%h t=%0d want v=1 r=4 t=9", out_valid, result, tag_out);
      end
      tick();
   endtask

   task automatic test_scoreboard();
      logic [XLEN:0]    q_exp [$];
      logic [TAG_W-1:0] q_tag [$];
      logic [XLEN:0]    e;
      logic [TAG_W-1:0] et;
      bit               pend, acc, cons;
      int               sent, cyc;
      pend = 0; sent = 0; cyc = 0;
      while ((sent < 60 || pend || q_exp.size() != 0) && cyc < 5000) begin
         if (!pend && sent < 60 && $urandom_range(0, 3) != 0) begin
            op = 4'($urandom_range(0, 15)); a = $urandom(); b = $urandom(); tag = 5'($urandom());
            pend = 1;
         end
         in_valid  = pend;
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         acc  = in_valid && in_ready;
         cons = out_valid && out_ready;
         if (cons) begin
            compared++;
            if (q_exp.size() == 0) begin
               mismatched++; $display("FAIL sb_unexpected: got result %h want no output", result);
            end else begin
               e = q_exp.pop_front(); et = q_tag.pop_front();
               if ({illegal, result, tag_out} !== {e, et}) begin
                  mismatched++;
                  $display("FAIL sb_result: got i=%b r=%h t=%0d want i=%b r=%h t=%0d",
                           illegal, result, tag_out, e[XLEN], e[XLEN-1:0], et);
               end
            end
         end
         if (acc) begin
            q_exp.push_back(ref_alu(op, a, b, 1'b1));
            q_tag.push_back(tag);
            pend = 0;
            sent++;
         end
         tick();
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      compared++;
      if (cyc >= 5000 || q_exp.size() != 0) begin
         mismatched++;
         $display("FAIL sb_drain: got %0d pending after %0d cycles want 0", q_exp.size(), cyc);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_add();
      test_stream();
      test_mul(4'd11, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F);
      test_mul(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      test_backpressure();
      test_illegal();
      test_reset_mid_mul();
      test_scoreboard();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got simulation still running want finished");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
